// File: rtl/extend_pkg.sv
// ============================================================================
// extend_pkg : extension-select encodings shared by decode and extend_unit
// Rev 1.0    : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package extend_pkg;

  typedef enum logic [1:0] {
    EXT_OP_ZE = 2'b00,
    EXT_OP_SE = 2'b01,
    EXT_OP_LS = 2'b10,
    EXT_OP_BR = 2'b11
  } ext_op_t;

endpackage

`default_nettype wire

// File: rtl/extend_core.sv
// ============================================================================
// extend_core : combinational immediate widening (ZE / SE / LS / BR)
// Build macro : EXTEND_BRANCH_EN enables the branch-offset form on EXT_OP_BR
// Rev 1.0     : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module extend_core
  import extend_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [1:0]        ext_op,
  input  logic [IMM_W-1:0]  im,
  output logic [DATA_W-1:0] out,
  output logic              op_err
);

  logic [DATA_W-1:0] w_ze;
  logic [DATA_W-1:0] w_se;
  logic [DATA_W-1:0] w_ls;

  assign w_ze = {{(DATA_W-IMM_W){1'b0}}, im};
  assign w_se = {{(DATA_W-IMM_W){im[IMM_W-1]}}, im};
  assign w_ls = {im, {(DATA_W-IMM_W){1'b0}}};

  always_comb begin
    out    = '0;
    op_err = 1'b0;
    case (ext_op_t'(ext_op))
      EXT_OP_ZE: out = w_ze;
      EXT_OP_SE: out = w_se;
      EXT_OP_LS: out = w_ls;
`ifdef EXTEND_BRANCH_EN
      EXT_OP_BR: out = {w_se[DATA_W-3:0], 2'b00};
`else
      EXT_OP_BR: op_err = 1'b1;
`endif
      default: begin
        out    = '0;
        op_err = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/extend_unit.sv
// ============================================================================
// extend_unit : immediate extender with optional registered, valid-qualified
//               output stage (REG_OUT). Build macro: EXTEND_BRANCH_EN.
// Rev 1.0     : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module extend_unit
  import extend_pkg::*;
#(
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter bit REG_OUT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        ext_op,
  input  logic [IMM_W-1:0]  im,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic              op_err
);

  logic [DATA_W-1:0] w_out;
  logic              w_op_err;

  extend_core #(
    .IMM_W  (IMM_W),
    .DATA_W (DATA_W)
  ) u_core (
    .ext_op (ext_op),
    .im     (im),
    .out    (w_out),
    .op_err (w_op_err)
  );

  generate
    if (REG_OUT) begin : g_reg
      logic              r_valid;
      logic [DATA_W-1:0] r_out;
      logic              r_op_err;

      // Data and error only move on accepted inputs; valid is a one-cycle echo.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid  <= 1'b0;
          r_out    <= '0;
          r_op_err <= 1'b0;
        end else begin
          r_valid <= in_valid;
          if (in_valid) begin
            r_out    <= w_out;
            r_op_err <= w_op_err;
          end
        end
      end

      assign out_valid = r_valid;
      assign out       = r_out;
      assign op_err    = r_op_err;
    end else begin : g_comb
      assign out_valid = in_valid;
      assign out       = w_out;
      assign op_err    = w_op_err;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_extend_unit.sv
// ============================================================================
// tb_extend_unit : directed vectors for extend_unit, registered and
//                  combinational builds side by side
// Rev 1.0        : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_extend_unit;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] im;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [1:0]  ext_op;
  logic [15:0] im;
  logic        out_valid_r, op_err_r;
  logic [31:0] out_r;
  logic        out_valid_c, op_err_c;
  logic [31:0] out_c;

  int total;
  int bad;

  vec_t vecs[12];

  extend_unit #(.IMM_W(16), .DATA_W(32), .REG_OUT(1'b1)) u_dut_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ext_op    (ext_op),
    .im        (im),
    .out_valid (out_valid_r),
    .out       (out_r),
    .op_err    (op_err_r)
  );

  extend_unit #(.IMM_W(16), .DATA_W(32), .REG_OUT(1'b0)) u_dut_comb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ext_op    (ext_op),
    .im        (im),
    .out_valid (out_valid_c),
    .out       (out_c),
    .op_err    (op_err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{2'b01, 16'hFFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{2'b00, 16'hFFFF, 32'h0000_FFFF, 1'b0};
    vecs[2]  = '{2'b10, 16'hFFFF, 32'hFFFF_0000, 1'b0};
    vecs[3]  = '{2'b01, 16'h7FFF, 32'h0000_7FFF, 1'b0};
    vecs[4]  = '{2'b00, 16'h7FFF, 32'h0000_7FFF, 1'b0};
    vecs[5]  = '{2'b10, 16'h7FFF, 32'h7FFF_0000, 1'b0};
`ifdef EXTEND_BRANCH_EN
    vecs[6]  = '{2'b11, 16'h0001, 32'h0000_0004, 1'b0};
    vecs[7]  = '{2'b11, 16'hFFFF, 32'hFFFF_FFFC, 1'b0};
    vecs[11] = '{2'b11, 16'h8000, 32'hFFFE_0000, 1'b0};
`else
    vecs[6]  = '{2'b11, 16'h0001, 32'h0000_0000, 1'b1};
    vecs[7]  = '{2'b11, 16'hFFFF, 32'h0000_0000, 1'b1};
    vecs[11] = '{2'b11, 16'h8000, 32'h0000_0000, 1'b1};
`endif
    vecs[8]  = '{2'b01, 16'h8000, 32'hFFFF_8000, 1'b0};
    vecs[9]  = '{2'b10, 16'h1234, 32'h1234_0000, 1'b0};
    vecs[10] = '{2'b00, 16'h8001, 32'h0000_8001, 1'b0};

    // Reset state, checked before any clock edge.
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ext_op   = 2'b00;
    im       = 16'h0000;
    #1;
    check("rst_out",   out_r,       32'h0);
    check("rst_valid", {31'b0, out_valid_r}, 32'h0);
    check("rst_err",   {31'b0, op_err_r},    32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_valid", {31'b0, out_valid_r}, 32'h0);

    // Back-to-back table stream; combinational build checked mid-cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      ext_op   = vecs[i].op;
      im       = vecs[i].im;
      #1;
      check($sformatf("comb_out[%0d]", i),   out_c, vecs[i].exp);
      check($sformatf("comb_err[%0d]", i),   {31'b0, op_err_c},    {31'b0, vecs[i].err});
      check($sformatf("comb_valid[%0d]", i), {31'b0, out_valid_c}, 32'h1);
      @(posedge clk); #1;
      check($sformatf("reg_out[%0d]", i),   out_r, vecs[i].exp);
      check($sformatf("reg_err[%0d]", i),   {31'b0, op_err_r},    {31'b0, vecs[i].err});
      check($sformatf("reg_valid[%0d]", i), {31'b0, out_valid_r}, 32'h1);
    end

    // Valid gating: data holds, valid drops.
    @(negedge clk);
    in_valid = 1'b1; ext_op = 2'b00; im = 16'h1234;
    @(posedge clk); #1;
    check("gate_out1",   out_r, 32'h0000_1234);
    check("gate_valid1", {31'b0, out_valid_r}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0; ext_op = 2'b01; im = 16'hFFFF;
    #1;
    check("gate_comb_valid", {31'b0, out_valid_c}, 32'h0);
    @(posedge clk); #1;
    check("gate_out2",   out_r, 32'h0000_1234);
    check("gate_valid2", {31'b0, out_valid_r}, 32'h0);
    check("gate_err2",   {31'b0, op_err_r},    32'h0);

    // Illegal/branch op latched, then held through an idle cycle with a different op.
    @(negedge clk);
    in_valid = 1'b1; ext_op = 2'b11; im = 16'h0001;
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0; ext_op = 2'b00; im = 16'h5555;
    @(posedge clk); #1;
`ifdef EXTEND_BRANCH_EN
    check("hold_br_out", out_r, 32'h0000_0004);
    check("hold_br_err", {31'b0, op_err_r}, 32'h0);
`else
    check("hold_br_out", out_r, 32'h0);
    check("hold_br_err", {31'b0, op_err_r}, 32'h1);
`endif

    // Mid-stream asynchronous reset between edges.
    @(negedge clk);
    in_valid = 1'b1; ext_op = 2'b01; im = 16'hFFFE;
    @(posedge clk); #1;
    check("pre_rst_out", out_r, 32'hFFFF_FFFE);
    @(negedge clk);
    im = 16'h8001;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_out",   out_r, 32'h0);
    check("arst_valid", {31'b0, out_valid_r}, 32'h0);
    check("arst_err",   {31'b0, op_err_r},    32'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", {31'b0, out_valid_r}, 32'h0);
    check("post_rst_out",   out_r, 32'h0);
    @(negedge clk);
    in_valid = 1'b1; ext_op = 2'b01; im = 16'h8000;
    @(posedge clk); #1;
    check("recover_out",   out_r, 32'hFFFF_8000);
    check("recover_valid", {31'b0, out_valid_r}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
